// File: rtl/jtag_scan_master_pkg.sv
// Shared opcodes, controller state encoding and TAP preamble tables for jtag_scan_master.
// Optional build macro used by the top: JTAG_TDO_SYNC_EN.
package jtag_scan_master_pkg;

  localparam logic [1:0] JTAG_OP_RESET    = 2'd0;
  localparam logic [1:0] JTAG_OP_IDLE     = 2'd1;
  localparam logic [1:0] JTAG_OP_SHIFT_IR = 2'd2;
  localparam logic [1:0] JTAG_OP_SHIFT_DR = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRE   = 3'd1,
    ST_SHIFT = 3'd2,
    ST_POST  = 3'd3,
    ST_RESP  = 3'd4
  } state_e;

  // Number of tck cycles spent in the tms preamble of each op.
  function automatic logic [2:0] pre_len(input logic [1:0] op);
    case (op)
      JTAG_OP_RESET:    return 3'd6;
      JTAG_OP_SHIFT_IR: return 3'd4;
      JTAG_OP_SHIFT_DR: return 3'd3;
      default:          return 3'd0;
    endcase
  endfunction

  function automatic logic pre_tms(input logic [1:0] op, input logic [2:0] idx);
    case (op)
      JTAG_OP_RESET:    return (idx < 3'd5);
      JTAG_OP_SHIFT_IR: return (idx < 3'd2);
      JTAG_OP_SHIFT_DR: return (idx == 3'd0);
      default:          return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/jtag_tck_gen.sv
// tck generator: CLK_DIV clk cycles per half-period, idles low while disabled,
// with single-cycle strobes asserted in the clk cycle whose closing edge moves tck.
module jtag_tck_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tck,
  output logic tck_rise,
  output logic tck_fall
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tck_q, tck_d;
  logic             term;

  always_comb begin
    term  = (cnt_q == CNT_W'(CLK_DIV - 1));
    cnt_d = cnt_q;
    tck_d = tck_q;
    if (!en) begin
      cnt_d = '0;
      tck_d = 1'b0;
    end else if (term) begin
      cnt_d = '0;
      tck_d = ~tck_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      tck_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tck_q <= tck_d;
    end
  end

  assign tck      = tck_q;
  assign tck_rise = en & term & ~tck_q;
  assign tck_fall = en & term & tck_q;

endmodule

// File: rtl/jtag_scan_master.sv
// JTAG TAP initiator: runs RESET / IDLE / SHIFT_IR / SHIFT_DR commands and returns tdo bits.
// Define JTAG_TDO_SYNC_EN to pass tdo through a 2-flop synchronizer (needs CLK_DIV >= 3).
module jtag_scan_master
  import jtag_scan_master_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int MAX_LEN = 64,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [LEN_W-1:0]   cmd_len,
  input  logic [MAX_LEN-1:0] cmd_data,
  output logic               rsp_valid,
  output logic               rsp_err,
  output logic [MAX_LEN-1:0] rsp_data,
  output logic               tck,
  output logic               tms,
  output logic               tdi,
  input  logic               tdo
);

  generate
    if (CLK_DIV < 2) begin : g_div_chk
      $error("jtag_scan_master: CLK_DIV must be >= 2");
    end
`ifdef JTAG_TDO_SYNC_EN
    if (CLK_DIV < 3) begin : g_sync_chk
      $error("jtag_scan_master: CLK_DIV must be >= 3 with the tdo synchronizer");
    end
`endif
  endgenerate

  state_e             state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [MAX_LEN-1:0] data_q, data_d;
  logic [LEN_W-1:0]   bit_q, bit_d;
  logic [2:0]         seq_q, seq_d;
  logic               tms_q, tms_d;
  logic               tdi_q, tdi_d;
  logic               cmd_ready_q, cmd_ready_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic               rsp_err_q, rsp_err_d;
  logic [MAX_LEN-1:0] rsp_data_q, rsp_data_d;

  logic               tck_en, tck_rise, tck_fall;
  logic               smp_stb, smp_bit;
  logic [LEN_W-1:0]   bit_nxt;
  logic               last_bit, is_scan, bad_len;

  assign tck_en = (state_q == ST_PRE) || (state_q == ST_SHIFT) || (state_q == ST_POST);

  jtag_tck_gen #(.CLK_DIV(CLK_DIV)) u_tck_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (tck_en),
    .tck      (tck),
    .tck_rise (tck_rise),
    .tck_fall (tck_fall)
  );

`ifdef JTAG_TDO_SYNC_EN
  // Sample strobe is delayed to line up with tdo leaving the synchronizer; still before the fall.
  logic tdo_s1_q, tdo_s2_q, rise_d1_q, rise_d2_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tdo_s1_q  <= 1'b0;
      tdo_s2_q  <= 1'b0;
      rise_d1_q <= 1'b0;
      rise_d2_q <= 1'b0;
    end else begin
      tdo_s1_q  <= tdo;
      tdo_s2_q  <= tdo_s1_q;
      rise_d1_q <= tck_rise;
      rise_d2_q <= rise_d1_q;
    end
  end

  assign smp_stb = rise_d2_q;
  assign smp_bit = tdo_s2_q;
`else
  assign smp_stb = tck_rise;
  assign smp_bit = tdo;
`endif

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    len_d       = len_q;
    data_d      = data_q;
    bit_d       = bit_q;
    seq_d       = seq_q;
    tms_d       = tms_q;
    tdi_d       = tdi_q;
    cmd_ready_d = cmd_ready_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = rsp_err_q;
    rsp_data_d  = rsp_data_q;
    bit_nxt     = bit_q + 1'b1;
    last_bit    = (bit_q == len_q - 1'b1);
    is_scan     = (op_q == JTAG_OP_SHIFT_IR) || (op_q == JTAG_OP_SHIFT_DR);
    bad_len     = (cmd_len == '0) || (cmd_len > LEN_W'(MAX_LEN));

    case (state_q)
      ST_IDLE: begin
        cmd_ready_d = 1'b1;
        if (cmd_valid && cmd_ready_q) begin
          cmd_ready_d = 1'b0;
          op_d        = cmd_op;
          len_d       = cmd_len;
          data_d      = cmd_data;
          rsp_data_d  = '0;
          rsp_err_d   = 1'b0;
          bit_d       = '0;
          seq_d       = '0;
          tdi_d       = 1'b0;
          if ((cmd_op == JTAG_OP_SHIFT_IR || cmd_op == JTAG_OP_SHIFT_DR) && bad_len) begin
            rsp_err_d = 1'b1;
            state_d   = ST_RESP;
          end else if (cmd_op == JTAG_OP_IDLE) begin
            tms_d   = 1'b0;
            state_d = (cmd_len == '0) ? ST_RESP : ST_SHIFT;
          end else begin
            tms_d   = pre_tms(cmd_op, 3'd0);
            state_d = ST_PRE;
          end
        end
      end

      ST_PRE: begin
        if (tck_fall) begin
          if (seq_q == pre_len(op_q) - 3'd1) begin
            if (op_q == JTAG_OP_RESET) begin
              state_d = ST_RESP;
            end else begin
              state_d = ST_SHIFT;
              bit_d   = '0;
              tms_d   = (len_q == LEN_W'(1));
              tdi_d   = data_q[0];
            end
          end else begin
            seq_d = seq_q + 3'd1;
            tms_d = pre_tms(op_q, seq_q + 3'd1);
          end
        end
      end

      ST_SHIFT: begin
        if (smp_stb && is_scan) begin
          rsp_data_d = rsp_data_q | (MAX_LEN'(smp_bit) << bit_q);
        end
        if (tck_fall) begin
          if (last_bit) begin
            tdi_d = 1'b0;
            if (is_scan) begin
              state_d = ST_POST;
              seq_d   = '0;
              tms_d   = 1'b1;
            end else begin
              state_d = ST_RESP;
            end
          end else begin
            bit_d = bit_nxt;
            tms_d = is_scan && (bit_nxt == len_q - 1'b1);
            tdi_d = is_scan && (|(data_q & (MAX_LEN'(1) << bit_nxt)));
          end
        end
      end

      // Exit1 -> Update -> Run-Test/Idle
      ST_POST: begin
        if (tck_fall) begin
          if (seq_q == 3'd0) begin
            seq_d = 3'd1;
            tms_d = 1'b0;
          end else begin
            state_d = ST_RESP;
          end
        end
      end

      ST_RESP: begin
        rsp_valid_d = 1'b1;
        cmd_ready_d = 1'b1;
        state_d     = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      op_q        <= JTAG_OP_RESET;
      len_q       <= '0;
      data_q      <= '0;
      bit_q       <= '0;
      seq_q       <= '0;
      tms_q       <= 1'b1;
      tdi_q       <= 1'b0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      len_q       <= len_d;
      data_q      <= data_d;
      bit_q       <= bit_d;
      seq_q       <= seq_d;
      tms_q       <= tms_d;
      tdi_q       <= tdi_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign tms       = tms_q;
  assign tdi       = tdi_q;
  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_jtag_scan_master.sv
// Directed bench for jtag_scan_master against a behavioural TAP (10-bit IR, 12-bit DR).
module tb_jtag_scan_master;
  import jtag_scan_master_pkg::*;

  localparam int CLK_DIV = 4;
  localparam int MAX_LEN = 64;
  localparam int LEN_W   = 7;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               cmd_valid = 1'b0;
  logic               cmd_ready;
  logic [1:0]         cmd_op = 2'd0;
  logic [LEN_W-1:0]   cmd_len = '0;
  logic [MAX_LEN-1:0] cmd_data = '0;
  logic               rsp_valid, rsp_err;
  logic [MAX_LEN-1:0] rsp_data;
  logic               tck, tms, tdi;
  logic               tdo = 1'b0;

  jtag_scan_master #(.CLK_DIV(CLK_DIV), .MAX_LEN(MAX_LEN)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_len   (cmd_len),
    .cmd_data  (cmd_data),
    .rsp_valid (rsp_valid),
    .rsp_err   (rsp_err),
    .rsp_data  (rsp_data),
    .tck       (tck),
    .tms       (tms),
    .tdi       (tdi),
    .tdo       (tdo)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- behavioural TAP ----------------
  typedef enum logic [3:0] {
    TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PAU_DR, EX2_DR, UPD_DR,
    SEL_IR, CAP_IR, SH_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR
  } tap_e;

  function automatic tap_e tap_next(input tap_e s, input logic m);
    case (s)
      TLR:     return m ? TLR    : RTI;
      RTI:     return m ? SEL_DR : RTI;
      SEL_DR:  return m ? SEL_IR : CAP_DR;
      CAP_DR:  return m ? EX1_DR : SH_DR;
      SH_DR:   return m ? EX1_DR : SH_DR;
      EX1_DR:  return m ? UPD_DR : PAU_DR;
      PAU_DR:  return m ? EX2_DR : PAU_DR;
      EX2_DR:  return m ? UPD_DR : SH_DR;
      UPD_DR:  return m ? SEL_DR : RTI;
      SEL_IR:  return m ? TLR    : CAP_IR;
      CAP_IR:  return m ? EX1_IR : SH_IR;
      SH_IR:   return m ? EX1_IR : SH_IR;
      EX1_IR:  return m ? UPD_IR : PAU_IR;
      PAU_IR:  return m ? EX2_IR : PAU_IR;
      EX2_IR:  return m ? UPD_IR : SH_IR;
      default: return m ? SEL_DR : RTI;
    endcase
  endfunction

  tap_e        tap_st    = TLR;
  logic [11:0] dr_cap    = 12'h000;
  logic [11:0] dr_sr     = 12'h000;
  logic [11:0] dr_upd    = 12'h000;
  logic [9:0]  ir_sr     = 10'h000;
  logic [9:0]  ir_reg    = 10'h000;
  int          tck_rises = 0;
  logic [31:0] tms_hist  = '0;

  always @(posedge tck) begin
    case (tap_st)
      CAP_DR:  dr_sr  <= dr_cap;
      SH_DR:   dr_sr  <= {tdi, dr_sr[11:1]};
      UPD_DR:  dr_upd <= dr_sr;
      CAP_IR:  ir_sr  <= 10'h001;
      SH_IR:   ir_sr  <= {tdi, ir_sr[9:1]};
      UPD_IR:  ir_reg <= ir_sr;
      default: ;
    endcase
    tap_st    <= tap_next(tap_st, tms);
    tck_rises <= tck_rises + 1;
    tms_hist  <= {tms_hist[30:0], tms};
  end

  always @(negedge tck) begin
    tdo <= (tap_st == SH_DR) ? dr_sr[0] : (tap_st == SH_IR) ? ir_sr[0] : 1'b0;
  end

  // ---------------- checking helpers ----------------
  int errors = 0;
  int checks = 0;
  int acc_cyc = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [1:0] op, input int len, input logic [63:0] data);
    int n = 0;
    while (!cmd_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) chk("ready_timeout", {63'd0, cmd_ready}, 64'd1);
    cmd_op    = op;
    cmd_len   = LEN_W'(len);
    cmd_data  = data;
    cmd_valid = 1'b1;
    @(negedge clk);
    acc_cyc   = cyc;
    cmd_valid = 1'b0;
    chk("busy_not_ready", {63'd0, cmd_ready}, 64'd0);
  endtask

  task automatic wait_rsp(input string tag, input int exp_lat);
    int n = 0;
    while (!rsp_valid && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_rsp_seen"}, {63'd0, rsp_valid}, 64'd1);
    chk({tag, "_latency"}, 64'(cyc - acc_cyc), 64'(exp_lat));
    @(negedge clk);
    chk({tag, "_pulse"}, {63'd0, rsp_valid}, 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0;
    int n;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_tck", {63'd0, tck}, 64'd0);
    chk("rst_tms", {63'd0, tms}, 64'd1);
    chk("rst_tdi", {63'd0, tdi}, 64'd0);
    chk("rst_ready", {63'd0, cmd_ready}, 64'd0);
    chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    chk("rst_rsp_err", {63'd0, rsp_err}, 64'd0);
    chk("rst_rsp_data", rsp_data, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", {63'd0, cmd_ready}, 64'd1);

    // RESET op: 6 tck, tms 1,1,1,1,1,0
    r0 = tck_rises;
    send(JTAG_OP_RESET, 0, 64'd0);
    wait_rsp("reset", 8 * 6 + 1);
    chk("reset_err", {63'd0, rsp_err}, 64'd0);
    chk("reset_tcks", 64'(tck_rises - r0), 64'd6);
    chk("reset_tms", {58'd0, tms_hist[5:0]}, 64'b111110);
    chk("reset_tap", {60'd0, tap_st}, {60'd0, RTI});

    // SHIFT_DR 12 bits
    dr_cap = 12'h3F1;
    r0 = tck_rises;
    send(JTAG_OP_SHIFT_DR, 12, 64'hA5C);
    wait_rsp("dr12", 8 * 17 + 1);
    chk("dr12_data", rsp_data, 64'h3F1);
    chk("dr12_err", {63'd0, rsp_err}, 64'd0);
    chk("dr12_tcks", 64'(tck_rises - r0), 64'd17);
    chk("dr12_tms", {47'd0, tms_hist[16:0]}, 64'b100_000000000001_10);
    chk("dr12_upd", {52'd0, dr_upd}, 64'hA5C);
    chk("dr12_tap", {60'd0, tap_st}, {60'd0, RTI});
    repeat (5) @(negedge clk);
    chk("dr12_hold", rsp_data, 64'h3F1);

    // SHIFT_IR 10 bits
    r0 = tck_rises;
    send(JTAG_OP_SHIFT_IR, 10, 64'h00E);
    wait_rsp("ir10", 8 * 16 + 1);
    chk("ir10_data", rsp_data, 64'h001);
    chk("ir10_ir", {54'd0, ir_reg}, 64'h00E);
    chk("ir10_tcks", 64'(tck_rises - r0), 64'd16);
    chk("ir10_tms", {48'd0, tms_hist[15:0]}, 64'b1100_0000000001_10);
    chk("ir10_tap", {60'd0, tap_st}, {60'd0, RTI});

    // SHIFT_DR at MAX_LEN: data streams through the 12-bit DR
    dr_cap = 12'hA5C;
    r0 = tck_rises;
    send(JTAG_OP_SHIFT_DR, 64, 64'h0123_4567_89AB_CDEF);
    wait_rsp("dr64", 8 * 69 + 1);
    chk("dr64_data", rsp_data, 64'h3456_789A_BCDE_FA5C);
    chk("dr64_upd", {52'd0, dr_upd}, 64'h012);
    chk("dr64_tcks", 64'(tck_rises - r0), 64'd69);

    // rejected lengths
    r0 = tck_rises;
    send(JTAG_OP_SHIFT_DR, 0, 64'hFFFF);
    wait_rsp("len0", 1);
    chk("len0_err", {63'd0, rsp_err}, 64'd1);
    chk("len0_data", rsp_data, 64'd0);
    chk("len0_tcks", 64'(tck_rises - r0), 64'd0);
    r0 = tck_rises;
    send(JTAG_OP_SHIFT_DR, MAX_LEN + 1, 64'hFFFF);
    wait_rsp("len65", 1);
    chk("len65_err", {63'd0, rsp_err}, 64'd1);
    chk("len65_tcks", 64'(tck_rises - r0), 64'd0);

    // IDLE op
    r0 = tck_rises;
    send(JTAG_OP_IDLE, 3, 64'd0);
    wait_rsp("idle3", 8 * 3 + 1);
    chk("idle3_err", {63'd0, rsp_err}, 64'd0);
    chk("idle3_tcks", 64'(tck_rises - r0), 64'd3);
    chk("idle3_tms", {61'd0, tms_hist[2:0]}, 64'd0);
    chk("idle3_tap", {60'd0, tap_st}, {60'd0, RTI});
    r0 = tck_rises;
    send(JTAG_OP_IDLE, 0, 64'd0);
    wait_rsp("idle0", 1);
    chk("idle0_tcks", 64'(tck_rises - r0), 64'd0);

    // reset during bit 5 of a 12-bit DR shift
    dr_cap = 12'h3F1;
    r0 = tck_rises;
    send(JTAG_OP_SHIFT_DR, 12, 64'h555);
    n = 0;
    while ((tck_rises - r0) < 9 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("abort_reach_bit5", 64'(tck_rises - r0), 64'd9);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_tck", {63'd0, tck}, 64'd0);
    chk("abort_tms", {63'd0, tms}, 64'd1);
    chk("abort_ready", {63'd0, cmd_ready}, 64'd0);
    for (int i = 0; i < 3; i++) begin
      chk("abort_no_rsp", {63'd0, rsp_valid}, 64'd0);
      @(negedge clk);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_ready_after", {63'd0, cmd_ready}, 64'd1);
    chk("abort_no_rsp_after", {63'd0, rsp_valid}, 64'd0);
    send(JTAG_OP_RESET, 0, 64'd0);
    wait_rsp("rereset", 8 * 6 + 1);
    chk("rereset_tap", {60'd0, tap_st}, {60'd0, RTI});
    dr_cap = 12'h5A3;
    send(JTAG_OP_SHIFT_DR, 12, 64'h0F0);
    wait_rsp("redr", 8 * 17 + 1);
    chk("redr_data", rsp_data, 64'h5A3);
    chk("redr_upd", {52'd0, dr_upd}, 64'h0F0);
    chk("redr_err", {63'd0, rsp_err}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
